debounce: RTL and testbench
===========================

# debounce

Synchronises and debounces one asynchronous, bouncy level input such as a switch or button. It produces a clean registered level and one-cycle edge pulses. It sits directly upstream of the single-bit `dff` capture stage: `q` drives that stage's `d`, while `rise` and `fall` feed downstream event logic.

## Interface
- `STABLE`, default 4: number of consecutive synchronised samples at the new level required to accept a change. Legal range is 2 ≤ STABLE ≤ 2**CNT_W.
- `CNT_W`, default 3: stability-counter width. It must hold the value STABLE-1.
- `c`  input  1  clock; all flops update on the rising edge.
- `r`  input  1  reset, **asynchronous, active-low**. `r=0` clears all state immediately, regardless of `c`.
- `d`  input  1  raw asynchronous input; may bounce or glitch.
- `q`  output  1  debounced level, registered.
- `rise`  output  1  one-cycle pulse, asserted in the same cycle `q` goes 0→1.
- `fall`  output  1  one-cycle pulse, asserted in the same cycle `q` goes 1→0.
- `busy`  output  1  high while a candidate change is being qualified, i.e. in state CHK_HI or CHK_LO.

## Operation
- `d` passes through a two-flop synchroniser (`s1`, then `s2`). Only `s2` is used by the FSM.
- FSM states are LO, CHK_HI, HI and CHK_LO. The counter `cnt` has CNT_W bits.
- **LO** (q=0):
  - s2=1 → CHK_HI, cnt←1.
  - otherwise stay in LO.
- **CHK_HI**:
  - s2=0 → LO, cnt←0; the candidate is abandoned with no pulse.
  - else if cnt==STABLE-1 → HI, q←1, rise←1, cnt←0.
  - else cnt←cnt+1.
- **HI** and **CHK_LO** are the mirror images, with q←0 and fall←1 on acceptance.
- `rise` and `fall` are registered, high for exactly one cycle, and never high together.
- `busy` is a registered or state-decoded output: (state==CHK_HI)||(state==CHK_LO).
- A change is accepted only after STABLE consecutive `s2` samples at the new level. Any shorter excursion is ignored entirely.
- `cnt` never exceeds STABLE-1 and never wraps.
- Reset values (asserted asynchronously while r=0):
  - s1=s2=0, state=LO, cnt=0.
  - q=0, rise=0, fall=0, busy=0.
- After reset is released with `d` held high, the block qualifies the high level normally. `q` rises after STABLE+2 edges, with a `rise` pulse.
- Reset asserted mid-qualification, or while HI, aborts immediately. No pulse is emitted on reset.

## Timing
- Latency from a `d` change to the `q` change (with its `rise`/`fall` pulse) is STABLE+2 rising edges of `c`:
  - 2 edges for the synchroniser.
  - STABLE edges for qualification.
- With defaults this is 6 edges. The first edge counted is the first one at which `d` meets setup at the new level.
- An excursion of up to STABLE-1 clock periods produces no `q` change. It may toggle `busy`.
- Continuous bouncing keeps the FSM cycling between the stable state and its CHK state. `q` changes exactly STABLE+2 edges after the last transition of `d`, provided `d` then holds.
- Simultaneous events:
  - If s2 returns to the old level on the same edge at which cnt==STABLE-1 would have accepted, the return wins (→ stable state, no pulse). This follows because acceptance requires s2 at the new level on that edge.
- Reset deassertion is assumed synchronous to `c` at system level. The block itself applies reset asynchronously.

## Structure
- Package `debounce_pkg`:
  - `typedef enum logic [1:0] {LO, CHK_HI, HI, CHK_LO} db_state_t`.
  - Default constants `DB_STABLE=4` and `DB_CNT_W=3`.
- Sub-module `sync2`: a two-flop synchroniser with the same `c`/`r` ports (async active-low reset to 0). It is reusable by other input stages.
- Top level: `sync2` plus the FSM and counter in one always block, with registered outputs.

## Test plan
All scenarios use the defaults (STABLE=4).

- **Reset:** hold r=0 for 3 cycles with d=1 and toggle `c` → q=rise=fall=busy=0 throughout. Drop r in mid-cycle → outputs are 0 immediately, with no clock edge required.
- **Clean rise:** after reset, set d=1 before edge 1 and hold → q=1 and rise=1 after edge 6. rise=0 after edge 7. busy is high after edges 3–5.
- **Glitch reject:** pulse d high for exactly 3 clock periods → q stays 0 and rise never asserts. Repeat with a 4-period pulse → q=1 after edge 6, then q returns to 0 with a fall pulse 6 edges after d falls.
- **Clean fall:** from q=1, set d=0 and hold → q=0 and fall=1 after edge 6, with a single pulse.
- **Bounce:** toggle d every cycle for 10 cycles, then hold 1 → exactly one rise pulse, occurring 6 edges after the final 0→1 transition. No fall pulse.
- **Reset mid-qualify:** assert r=0 while busy=1 (cnt=2) → busy=0, q=0, no pulse. Release r with d=1 → q rises 6 edges later, with a single rise pulse.

Source files
------------

// File: rtl/debounce_pkg.sv
// debounce_pkg: shared types and default constants for the debounce block.
//   db_state_t - FSM state encoding (stable low, qualifying high, stable high, qualifying low)
//   DB_STABLE  - default number of consecutive samples needed to accept a level change
//   DB_CNT_W   - default stability-counter width (must hold DB_STABLE-1)
package debounce_pkg;

    typedef enum logic [1:0] {
        LO,
        CHK_HI,
        HI,
        CHK_LO
    } db_state_t;

    localparam int unsigned DB_STABLE = 4;
    localparam int unsigned DB_CNT_W  = 3;

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchroniser for one asynchronous level input.
// Ports:
//   c - clock, rising edge
//   r - asynchronous active-low reset; clears both flops to 0
//   d - asynchronous input
//   q - synchronised output (second flop)
module sync2 (
    input  logic c,
    input  logic r,
    input  logic d,
    output logic q
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge c or negedge r) begin
        if (!r) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/debounce.sv
// debounce: synchronises and debounces one bouncy level input.
// A new level is accepted only after STABLE consecutive synchronised samples at that level;
// any shorter excursion is dropped without a pulse.
// Ports:
//   c    - clock, rising edge
//   r    - asynchronous active-low reset; clears all state
//   d    - raw asynchronous input
//   q    - debounced level (registered)
//   rise - one-cycle pulse in the cycle q goes 0->1 (registered)
//   fall - one-cycle pulse in the cycle q goes 1->0 (registered)
//   busy - high while a candidate change is being qualified
module debounce
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE = DB_STABLE,
    parameter int unsigned CNT_W  = DB_CNT_W
) (
    input  logic c,
    input  logic r,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic s2;

    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             q_q, q_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    sync2 u_sync2 (
        .c (c),
        .r (r),
        .d (d),
        .q (s2)
    );

    // The first sample at the new level is counted on the transition into CHK_*, so
    // cnt==STABLE-1 with s2 still at the new level is the STABLE-th consecutive sample.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            LO: begin
                if (s2) begin
                    state_d = CHK_HI;
                    cnt_d   = CNT_ONE;
                end
            end
            CHK_HI: begin
                if (!s2) begin
                    state_d = LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = HI;
                    q_d     = 1'b1;
                    rise_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HI: begin
                if (!s2) begin
                    state_d = CHK_LO;
                    cnt_d   = CNT_ONE;
                end
            end
            CHK_LO: begin
                if (s2) begin
                    state_d = HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = LO;
                    q_d     = 1'b0;
                    fall_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = LO;
                cnt_d   = '0;
                q_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge c or negedge r) begin
        if (!r) begin
            state_q <= LO;
            cnt_q   <= '0;
            q_q     <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign q    = q_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = (state_q == CHK_HI) || (state_q == CHK_LO);

endmodule

// File: tb/tb_debounce.sv
module tb_debounce;

    localparam int STABLE = 4;
    localparam int LAT    = STABLE + 2;

    logic c = 1'b0;
    logic r = 1'b0;
    logic d = 1'b0;
    logic q, rise, fall, busy;

    int checks = 0;
    int errors = 0;

    // Reference model: input delayed two edges, then a run-length of samples that
    // disagree with the accepted level; STABLE of them in a row flips the level.
    logic m_p1, m_p2;
    logic m_q, m_rise, m_fall;
    int   m_run;

    // Observation bookkeeping for directed scenarios.
    int edge_no;
    int rise_cnt, fall_cnt, rise_edge, fall_edge;

    debounce #(.STABLE(STABLE), .CNT_W(3)) dut (
        .c    (c),
        .r    (r),
        .d    (d),
        .q    (q),
        .rise (rise),
        .fall (fall),
        .busy (busy)
    );

    always #5 c = ~c;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_p1   = 1'b0;
        m_p2   = 1'b0;
        m_q    = 1'b0;
        m_rise = 1'b0;
        m_fall = 1'b0;
        m_run  = 0;
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".q"}, q, m_q);
        chk({tag, ".rise"}, rise, m_rise);
        chk({tag, ".fall"}, fall, m_fall);
        chk({tag, ".busy"}, busy, m_run != 0);
    endtask

    task automatic clear_obs();
        edge_no   = 0;
        rise_cnt  = 0;
        fall_cnt  = 0;
        rise_edge = -1;
        fall_edge = -1;
    endtask

    // One rising edge: advance the model, then compare 1 time unit later.
    task automatic step(input string tag);
        logic seen;
        @(posedge c);
        if (!r) begin
            model_reset();
        end else begin
            seen   = m_p2;
            m_p2   = m_p1;
            m_p1   = d;
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (seen != m_q) begin
                m_run++;
                if (m_run == STABLE) begin
                    m_q    = seen;
                    m_rise = seen;
                    m_fall = !seen;
                    m_run  = 0;
                end
            end else begin
                m_run = 0;
            end
        end
        #1;
        edge_no++;
        compare_all(tag);
        if (rise) begin
            rise_cnt++;
            rise_edge = edge_no;
        end
        if (fall) begin
            fall_cnt++;
            fall_edge = edge_no;
        end
    endtask

    task automatic steps(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    initial begin
        int len;
        int last_tr;

        model_reset();
        clear_obs();

        // Reset held with d high while clocking.
        d = 1'b1;
        #1;
        compare_all("rst_init");
        steps("rst_hold", 3);

        // Clean rise: release reset away from an edge with d high.
        r = 1'b1;
        clear_obs();
        steps("rise_a", 2);
        chk("rise_busy2", busy, 1'b0);
        step("rise_b");
        chk("rise_busy3", busy, 1'b1);
        steps("rise_c", 2);
        chk("rise_busy5", busy, 1'b1);
        step("rise_d");
        chk("rise_q6", q, 1'b1);
        chk("rise_pulse6", rise, 1'b1);
        step("rise_e");
        chk("rise_pulse7", rise, 1'b0);
        chk_int("rise_count", rise_cnt, 1);

        // Clean fall.
        d = 1'b0;
        clear_obs();
        steps("fall", 8);
        chk_int("fall_edge", fall_edge, LAT);
        chk_int("fall_count", fall_cnt, 1);
        chk("fall_q", q, 1'b0);

        // Glitch of STABLE-1 periods is ignored.
        clear_obs();
        d = 1'b1;
        steps("glitch3_hi", 3);
        d = 1'b0;
        steps("glitch3_lo", 8);
        chk_int("glitch3_rises", rise_cnt, 0);
        chk("glitch3_q", q, 1'b0);

        // Glitch of STABLE periods is accepted, then released.
        clear_obs();
        d = 1'b1;
        steps("glitch4_hi", 4);
        d = 1'b0;
        steps("glitch4_lo", 10);
        chk_int("glitch4_rise_edge", rise_edge, LAT);
        chk_int("glitch4_fall_edge", fall_edge, 4 + LAT);

        // Bounce: toggle each cycle, then hold high.
        clear_obs();
        for (int i = 0; i < 10; i++) begin
            d = (i % 2 == 0);
            step("bounce");
        end
        last_tr = edge_no;
        d = 1'b1;
        steps("bounce_hold", 10);
        chk_int("bounce_rises", rise_cnt, 1);
        chk_int("bounce_falls", fall_cnt, 0);
        chk_int("bounce_rise_edge", rise_edge - last_tr, LAT);

        // Reset mid-qualification, asserted between edges.
        d = 1'b0;
        steps("mid_fall", 8);
        clear_obs();
        d = 1'b1;
        steps("mid_q", 4);
        chk("mid_busy_pre", busy, 1'b1);
        #2;
        r = 1'b0;
        model_reset();
        #1;
        compare_all("mid_async");
        chk("mid_busy_async", busy, 1'b0);
        steps("mid_hold", 2);
        r = 1'b1;
        clear_obs();
        steps("mid_rel", 8);
        chk_int("mid_rise_edge", rise_edge, LAT);
        chk_int("mid_rise_count", rise_cnt, 1);

        // Reset while HI aborts with no pulse.
        #2;
        r = 1'b0;
        model_reset();
        #1;
        compare_all("hi_async");
        d = 1'b0;
        step("hi_hold");
        r = 1'b1;

        // Randomised runs of held levels with occasional asynchronous resets.
        for (int b = 0; b < 120; b++) begin
            d   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 9);
            steps("rand", len);
            if ($urandom_range(0, 19) == 0) begin
                #2;
                r = 1'b0;
                model_reset();
                #1;
                compare_all("rand_async");
                step("rand_rst");
                r = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
